// File: rtl/prog_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
interface prog_loader_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;

  // Loader side: consumes the stream, drives the memory write port.
  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

  // Source/memory side: produces the stream, observes the writes.
  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/prog_loader.sv
// Program image loader: receives a framed image (LEN, payload, CHK) and writes
// the payload to instruction memory from address 0. The CPU is held in reset
// until a frame with a good checksum has been written.
module prog_loader #(
  parameter int UUID = 0,
  parameter     NAME = ""
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  prog_loader_if.slave  bus,
  output logic          cpu_hold,
  output logic          busy,
  output logic          done,
  output logic          error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_CHK,
    S_DONE,
    S_ERR
  } state_t;

  state_t     state_q, state_d;
  logic [8:0] cnt_q, cnt_d;        // payload bytes still to come; 256 fits
  logic [7:0] sum_q, sum_d;
  logic [7:0] addr_q, addr_d;
  logic       in_ready_q, in_ready_d;
  logic       mem_we_q, mem_we_d;
  logic [7:0] mem_addr_q, mem_addr_d;
  logic [7:0] mem_wdata_q, mem_wdata_d;
  logic       cpu_hold_q, cpu_hold_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       error_q, error_d;

  logic       xfer;
  logic [7:0] chk_sum;

  assign xfer    = bus.in_valid && in_ready_q;
  assign chk_sum = sum_q + bus.in_data;

  // Next-state and next-output computation for the frame FSM.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    addr_d      = addr_q;
    in_ready_d  = in_ready_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_hold_d  = cpu_hold_q;
    busy_d      = busy_q;
    done_d      = done_q;
    error_d     = error_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d    = S_LEN;
          done_d     = 1'b0;
          error_d    = 1'b0;
          cpu_hold_d = 1'b1;
          busy_d     = 1'b1;
          in_ready_d = 1'b1;
        end
      end
      S_LEN: begin
        if (xfer) begin
          cnt_d   = (bus.in_data == 8'd0) ? 9'd256 : {1'b0, bus.in_data};
          sum_d   = bus.in_data;
          addr_d  = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (xfer) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = addr_q;
          mem_wdata_d = bus.in_data;
          sum_d       = sum_q + bus.in_data;
          addr_d      = addr_q + 8'd1;
          cnt_d       = cnt_q - 9'd1;
          if (cnt_q == 9'd1) begin
            state_d = S_CHK;
          end
        end
      end
      S_CHK: begin
        if (xfer) begin
          in_ready_d = 1'b0;
          busy_d     = 1'b0;
          if (chk_sum == 8'd0) begin
            state_d    = S_DONE;
            done_d     = 1'b1;
            cpu_hold_d = 1'b0;
          end else begin
            state_d    = S_ERR;
            error_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d    = S_IDLE;
        in_ready_d = 1'b0;
        busy_d     = 1'b0;
        cpu_hold_d = 1'b1;
      end
    endcase
  end

  // State and registered outputs; reset parks the loader with the CPU held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      sum_q       <= '0;
      addr_q      <= '0;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_hold_q  <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      addr_q      <= addr_d;
      in_ready_q  <= in_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_hold_q  <= cpu_hold_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign cpu_hold      = cpu_hold_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: framed loads, checksum failure, stalls,
// 256-byte wrap, start while busy and reset mid-frame.
module tb_prog_loader;

  typedef logic [7:0]  byte_q_t[$];
  typedef logic [15:0] wr_q_t[$];

  logic clk;
  logic rst;
  logic start;
  logic cpu_hold, busy, done, error;

  prog_loader_if bus ();

  prog_loader #(.UUID(1), .NAME("tb_loader")) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bus      (bus),
    .cpu_hold (cpu_hold),
    .busy     (busy),
    .done     (done),
    .error    (error)
  );

  int total = 0;
  int bad   = 0;

  wr_q_t wr_q;      // {addr, data} of every observed write
  int    spur;      // edges where mem_we disagreed with a payload transfer
  bit    timeout;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle start pulse; returns at the negedge after the sampling edge.
  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Streams a frame from the LEN state, logging writes and mem_we agreement.
  task automatic drive_frame(input byte_q_t bytes, input bit stall, input bit spam);
    int  idx = 0;
    int  cyc = 0;
    bit  xfer;
    bit  exp_we;
    wr_q.delete();
    spur    = 0;
    timeout = 1'b0;
    while (idx < bytes.size() && cyc < 5000) begin
      bus.in_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.in_data  = bytes[idx];
      if (spam) start = 1'b1;
      xfer   = bus.in_valid && bus.in_ready;
      exp_we = xfer && (idx >= 1) && (idx <= bytes.size() - 2);
      @(posedge clk);
      @(negedge clk);
      if (bus.mem_we) wr_q.push_back({bus.mem_addr, bus.mem_wdata});
      if (bus.mem_we !== exp_we) spur++;
      if (xfer) idx++;
      cyc++;
    end
    bus.in_valid = 1'b0;
    start        = 1'b0;
    if (idx < bytes.size()) timeout = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    repeat (2) @(negedge clk);
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready); end
    total++; if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL reset_mem_we got=%b exp=0", bus.mem_we); end
    total++; if ({bus.mem_addr, bus.mem_wdata} !== 16'h0000) begin bad++; $display("FAIL reset_mem_bus got=%h exp=0000", {bus.mem_addr, bus.mem_wdata}); end
    total++; if ({cpu_hold, busy, done, error} !== 4'b1000) begin bad++; $display("FAIL reset_status got=%b exp=1000", {cpu_hold, busy, done, error}); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_good_frame();
    byte_q_t f = '{8'h03, 8'h10, 8'h20, 8'h30, 8'h9D};
    logic [15:0] exp_w [3] = '{16'h0010, 16'h0120, 16'h0230};
    do_start();
    total++; if ({bus.in_ready, busy, cpu_hold} !== 3'b111) begin bad++; $display("FAIL start_accept got=%b exp=111", {bus.in_ready, busy, cpu_hold}); end
    drive_frame(f, 1'b0, 1'b0);
    total++; if (timeout || spur != 0) begin bad++; $display("FAIL good_timing got=timeout%0d/spur%0d exp=0/0", timeout, spur); end
    total++; if (wr_q.size() != 3) begin bad++; $display("FAIL good_nwrites got=%0d exp=3", wr_q.size()); end
    for (int i = 0; i < 3 && i < wr_q.size(); i++) begin
      total++; if (wr_q[i] !== exp_w[i]) begin bad++; $display("FAIL good_write%0d got=%h exp=%h", i, wr_q[i], exp_w[i]); end
    end
    total++; if ({done, error, cpu_hold, busy, bus.in_ready} !== 5'b10000) begin bad++; $display("FAIL good_status got=%b exp=10000", {done, error, cpu_hold, busy, bus.in_ready}); end
  endtask

  task automatic test_bad_checksum();
    byte_q_t f = '{8'h03, 8'h10, 8'h20, 8'h30, 8'h9C};
    byte_q_t g = '{8'h03, 8'h10, 8'h20, 8'h30, 8'h9D};
    logic [15:0] exp_w [3] = '{16'h0010, 16'h0120, 16'h0230};
    do_start();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL restart_clears_done got=%b exp=0", done); end
    drive_frame(f, 1'b0, 1'b0);
    total++; if (wr_q.size() != 3 || spur != 0) begin bad++; $display("FAIL bad_nwrites got=%0d/spur%0d exp=3/0", wr_q.size(), spur); end
    for (int i = 0; i < 3 && i < wr_q.size(); i++) begin
      total++; if (wr_q[i] !== exp_w[i]) begin bad++; $display("FAIL bad_write%0d got=%h exp=%h", i, wr_q[i], exp_w[i]); end
    end
    total++; if ({done, error, cpu_hold, busy} !== 4'b0110) begin bad++; $display("FAIL bad_status got=%b exp=0110", {done, error, cpu_hold, busy}); end
    do_start();
    total++; if ({error, busy, bus.in_ready} !== 3'b011) begin bad++; $display("FAIL err_clear got=%b exp=011", {error, busy, bus.in_ready}); end
    drive_frame(g, 1'b0, 1'b0);
    total++; if ({done, error, cpu_hold} !== 3'b100 || wr_q.size() != 3) begin bad++; $display("FAIL reload_status got=%b/%0d exp=100/3", {done, error, cpu_hold}, wr_q.size()); end
  endtask

  task automatic test_stall();
    byte_q_t f = '{8'h05, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'hEC};
    do_start();
    drive_frame(f, 1'b1, 1'b0);
    total++; if (timeout || spur != 0) begin bad++; $display("FAIL stall_we got=timeout%0d/spur%0d exp=0/0", timeout, spur); end
    total++; if (wr_q.size() != 5) begin bad++; $display("FAIL stall_nwrites got=%0d exp=5", wr_q.size()); end
    for (int i = 0; i < 5 && i < wr_q.size(); i++) begin
      total++; if (wr_q[i] !== {8'(i), 8'(i + 1)}) begin bad++; $display("FAIL stall_write%0d got=%h exp=%h", i, wr_q[i], {8'(i), 8'(i + 1)}); end
    end
    total++; if ({done, error, cpu_hold} !== 3'b100) begin bad++; $display("FAIL stall_status got=%b exp=100", {done, error, cpu_hold}); end
  endtask

  task automatic test_len256();
    byte_q_t f;
    int nbad = 0;
    f.push_back(8'h00);
    for (int i = 0; i < 256; i++) f.push_back(8'h01);
    f.push_back(8'h00);
    do_start();
    drive_frame(f, 1'b0, 1'b0);
    total++; if (timeout || spur != 0) begin bad++; $display("FAIL len256_we got=timeout%0d/spur%0d exp=0/0", timeout, spur); end
    total++; if (wr_q.size() != 256) begin bad++; $display("FAIL len256_nwrites got=%0d exp=256", wr_q.size()); end
    for (int i = 0; i < 256 && i < wr_q.size(); i++)
      if (wr_q[i] !== {8'(i), 8'h01}) nbad++;
    total++; if (nbad != 0) begin bad++; $display("FAIL len256_addrs got=%0d wrong exp=0 wrong", nbad); end
    total++; if ({done, error, cpu_hold, busy} !== 4'b1000) begin bad++; $display("FAIL len256_status got=%b exp=1000", {done, error, cpu_hold, busy}); end
  endtask

  task automatic test_start_while_busy();
    byte_q_t f = '{8'h02, 8'hAA, 8'h55, 8'hFF};
    do_start();
    drive_frame(f, 1'b0, 1'b1);
    total++; if (timeout || spur != 0 || wr_q.size() != 2) begin bad++; $display("FAIL spam_writes got=%0d/spur%0d exp=2/0", wr_q.size(), spur); end
    if (wr_q.size() == 2) begin
      total++; if (wr_q[0] !== 16'h00AA || wr_q[1] !== 16'h0155) begin bad++; $display("FAIL spam_data got=%h,%h exp=00aa,0155", wr_q[0], wr_q[1]); end
    end
    total++; if ({done, busy, bus.in_ready, cpu_hold} !== 4'b1000) begin bad++; $display("FAIL spam_no_restart got=%b exp=1000", {done, busy, bus.in_ready, cpu_hold}); end
  endtask

  task automatic test_reset_mid_frame();
    byte_q_t g = '{8'h01, 8'h7E, 8'h81};
    do_start();
    bus.in_valid = 1'b1;
    bus.in_data = 8'h04;
    @(negedge clk);
    bus.in_data = 8'hA1;
    @(negedge clk);
    bus.in_data = 8'hA2;
    @(negedge clk);
    total++; if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, 8'h01, 8'hA2}) begin bad++; $display("FAIL mid_second_write got=%h exp=101a2", {bus.mem_we, bus.mem_addr, bus.mem_wdata}); end
    #2 rst = 1'b0;
    #1;
    total++; if ({bus.in_ready, bus.mem_we, cpu_hold, busy, done, error} !== 6'b001000) begin bad++; $display("FAIL mid_reset got=%b exp=001000", {bus.in_ready, bus.mem_we, cpu_hold, busy, done, error}); end
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    do_start();
    drive_frame(g, 1'b0, 1'b0);
    total++; if (wr_q.size() != 1 || spur != 0) begin bad++; $display("FAIL fresh_nwrites got=%0d/spur%0d exp=1/0", wr_q.size(), spur); end
    if (wr_q.size() == 1) begin
      total++; if (wr_q[0] !== 16'h007E) begin bad++; $display("FAIL fresh_write got=%h exp=007e", wr_q[0]); end
    end
    total++; if ({done, error, cpu_hold} !== 3'b100) begin bad++; $display("FAIL fresh_status got=%b exp=100", {done, error, cpu_hold}); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_stall();
    test_len256();
    test_start_while_busy();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
